// File: rtl/hash_result_scanner_pkg.sv
// ---------------------------------------------------------------------------
// hash_result_scanner_pkg
//   Shared miner definitions used by the result scanner and its comparator:
//   default batch geometry (lane count, digest width, nonce width) and the
//   scanner state encoding.
// ---------------------------------------------------------------------------
package hash_result_scanner_pkg;

    // Default batch geometry: ten SHA lanes, 256-bit digests, 32-bit nonces.
    localparam int DEF_NUM_LANES = 10;
    localparam int DEF_IDX_W     = 4;
    localparam int DEF_HASH_W    = 256;
    localparam int DEF_NONCE_W   = 32;

    // Scanner control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } scanState_t;

endpackage : hash_result_scanner_pkg

// File: rtl/hash_result_scanner_lt_compare.sv
// ---------------------------------------------------------------------------
// hash_lt_compare
//   Purely combinational unsigned strict less-than of two WIDTH-bit words.
//   Equal operands give lt = 0.
//
// Ports
//   a   in  [WIDTH-1:0]  left operand (lane digest)
//   b   in  [WIDTH-1:0]  right operand (difficulty target)
//   lt  out              1 when a < b, unsigned
// ---------------------------------------------------------------------------
module hash_lt_compare
    import hash_result_scanner_pkg::*;
#(
    parameter int WIDTH = DEF_HASH_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt
);

    assign lt = (a < b);

endmodule : hash_lt_compare

// File: rtl/hash_result_scanner.sv
// ---------------------------------------------------------------------------
// hash_result_scanner
//   Scans a completed batch of NUM_LANES SHA digests, one lane per cycle,
//   looking for the first digest strictly below the difficulty target.
//   The batch (digests, target, base nonce) is captured on an accepted start
//   so the hashing core may move on to the next batch immediately.
//
// Ports
//   clk          in                     single clock, rising edge
//   n_rst        in                     asynchronous active-low reset
//   start        in                     one-cycle pulse: batch ready to scan
//   hashes       in  [NUM_LANES*HASH_W] packed digests, lane i at bits i*HASH_W
//   target       in  [HASH_W]           difficulty target
//   base_nonce   in  [NONCE_W]          nonce of lane 0
//   abort        in                     new-message clear, wins over start
//   busy         out                    high while scanning or reporting
//   done         out                    one-cycle pulse when the scan ends
//   found        out                    last completed scan found a hit
//   found_index  out [IDX_W]            winning lane
//   found_nonce  out [NONCE_W]          winning nonce (base_nonce + lane)
//   overrun      out                    sticky: start arrived while busy
// ---------------------------------------------------------------------------
module hash_result_scanner
    import hash_result_scanner_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int HASH_W    = DEF_HASH_W,
    parameter int NONCE_W   = DEF_NONCE_W
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    input  logic [NUM_LANES*HASH_W-1:0] hashes,
    input  logic [HASH_W-1:0]           target,
    input  logic [NONCE_W-1:0]          base_nonce,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic [IDX_W-1:0]            found_index,
    output logic [NONCE_W-1:0]          found_nonce,
    output logic                        overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    scanState_t          state;
    logic [IDX_W-1:0]    idx;

    logic [HASH_W-1:0]   laneIn  [NUM_LANES];
    logic [HASH_W-1:0]   laneReg [NUM_LANES];
    logic [HASH_W-1:0]   targetReg;
    logic [NONCE_W-1:0]  baseReg;

    logic [HASH_W-1:0]   laneSel;
    logic                laneHit;
    logic                acceptStart;

    // Unpack the flat digest bus into per-lane words.
    for (genvar g = 0; g < NUM_LANES; g++) begin : gUnpack
        assign laneIn[g] = hashes[g*HASH_W +: HASH_W];
    end

    // A start is taken only from IDLE and only when abort is not asserted.
    assign acceptStart = start && !abort && (state == ST_IDLE);

    // Batch capture. These wide data registers need no reset: they are only
    // read in SCAN, which is reachable solely through a capturing start.
    always_ff @(posedge clk) begin
        if (acceptStart) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                laneReg[i] <= laneIn[i];
            end
            targetReg <= target;
            baseReg   <= base_nonce;
        end
    end

    // One comparator shared by all lanes, steered by the scan index.
    assign laneSel = laneReg[idx];

    hash_lt_compare #(
        .WIDTH (HASH_W)
    ) uLtCompare (
        .a  (laneSel),
        .b  (targetReg),
        .lt (laneHit)
    );

    // Control FSM with registered outputs. done is raised on the transition
    // into REPORT so it is high exactly for the single REPORT cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_index <= '0;
            found_nonce <= '0;
            overrun     <= 1'b0;
        end else if (abort) begin
            state       <= ST_IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_index <= '0;
            found_nonce <= '0;
            overrun     <= 1'b0;
        end else begin
            done <= 1'b0;

            if (start && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx         <= '0;
                        found       <= 1'b0;
                        found_index <= '0;
                        found_nonce <= '0;
                        busy        <= 1'b1;
                        state       <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (laneHit) begin
                        found       <= 1'b1;
                        found_index <= idx;
                        found_nonce <= baseReg + NONCE_W'(idx);
                        done        <= 1'b1;
                        state       <= ST_REPORT;
                    end else if (idx == LAST_IDX) begin
                        done        <= 1'b1;
                        state       <= ST_REPORT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                ST_REPORT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : hash_result_scanner

// File: tb/tb_hash_result_scanner.sv
module tb_hash_result_scanner;

    localparam int NL = 10;
    localparam int IW = 4;
    localparam int HW = 256;
    localparam int NW = 32;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic [NL*HW-1:0]  hashes;
    logic [HW-1:0]     target;
    logic [NW-1:0]     base_nonce;
    logic              abort;
    logic              busy;
    logic              done;
    logic              found;
    logic [IW-1:0]     found_index;
    logic [NW-1:0]     found_nonce;
    logic              overrun;

    hash_result_scanner #(
        .NUM_LANES (NL),
        .IDX_W     (IW),
        .HASH_W    (HW),
        .NONCE_W   (NW)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .hashes      (hashes),
        .target      (target),
        .base_nonce  (base_nonce),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .found_index (found_index),
        .found_nonce (found_nonce),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: works from the batch-level rules (first lane below
    // target, latency t+k+2 or t+NL+1, results appear with done).
    // ------------------------------------------------------------------
    int            cyc     = 0;
    int            mStart  = 0;
    int            mDoneAt = 0;
    bit            mActive = 1'b0;
    logic          pFound  = 1'b0;
    logic [IW-1:0] pIdx    = '0;
    logic [NW-1:0] pNonce  = '0;

    logic          eBusy   = 1'b0;
    logic          eDone   = 1'b0;
    logic          eFound  = 1'b0;
    logic [IW-1:0] eIdx    = '0;
    logic [NW-1:0] eNonce  = '0;
    logic          eOver   = 1'b0;

    function automatic int firstHit(input logic [NL*HW-1:0] h, input logic [HW-1:0] t);
        logic [NL*HW-1:0] s;
        s = h;
        for (int i = 0; i < NL; i++) begin
            if (s[HW-1:0] < t) return i;
            s = s >> HW;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        int  c, nxt, k, dAt;
        bit  busyNow;
        if (!n_rst) begin
            if (clk) cyc <= cyc + 1;
            mActive <= 1'b0;
            eBusy <= 1'b0; eDone <= 1'b0; eFound <= 1'b0;
            eIdx <= '0; eNonce <= '0; eOver <= 1'b0;
        end else begin
            c   = cyc;
            nxt = c + 1;
            cyc <= nxt;
            busyNow = mActive && (c > mStart) && (c <= mDoneAt);
            if (abort) begin
                mActive <= 1'b0;
                eBusy <= 1'b0; eDone <= 1'b0; eFound <= 1'b0;
                eIdx <= '0; eNonce <= '0; eOver <= 1'b0;
            end else if (start && !busyNow) begin
                k   = firstHit(hashes, target);
                dAt = (k >= 0) ? c + k + 2 : c + NL + 1;
                mStart  <= c;
                mDoneAt <= dAt;
                mActive <= 1'b1;
                pFound  <= (k >= 0);
                pIdx    <= (k >= 0) ? IW'(k) : '0;
                pNonce  <= (k >= 0) ? base_nonce + NW'(k) : '0;
                eBusy <= 1'b1; eDone <= 1'b0; eFound <= 1'b0;
                eIdx <= '0; eNonce <= '0;
            end else begin
                if (start) eOver <= 1'b1;
                eBusy <= mActive && (nxt > mStart) && (nxt <= mDoneAt);
                eDone <= mActive && (nxt == mDoneAt);
                if (mActive && (nxt == mDoneAt)) begin
                    eFound <= pFound;
                    eIdx   <= pIdx;
                    eNonce <= pNonce;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    bit chkEn = 1'b0;
    int doneCount = 0;

    always @(negedge clk) begin
        if (chkEn) begin
            check("busy",        32'(busy),        32'(eBusy));
            check("done",        32'(done),        32'(eDone));
            check("found",       32'(found),       32'(eFound));
            check("found_index", 32'(found_index), 32'(eIdx));
            check("found_nonce", found_nonce,      eNonce);
            check("overrun",     32'(overrun),     32'(eOver));
            if (done) doneCount <= doneCount + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [HW-1:0] lane [NL];

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic applyLanes();
        logic [NL*HW-1:0] tmp;
        tmp = '0;
        for (int i = NL - 1; i >= 0; i--) tmp = {tmp[NL*HW-HW-1:0], lane[i]};
        hashes = tmp;
    endtask

    task automatic fillAll(input logic [HW-1:0] v);
        for (int i = 0; i < NL; i++) lane[i] = v;
    endtask

    function automatic logic [HW-1:0] rand256();
        logic [HW-1:0] r;
        r = '0;
        for (int i = 0; i < HW / 32; i++) r = {r[HW-33:0], 32'($urandom)};
        return r;
    endfunction

    // Launch a batch and wait (bounded) for done; returns latency in cycles.
    task automatic runBatch(input string nm, output int lat);
        int t;
        applyLanes();
        start = 1'b1;
        t = cyc;
        step();
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 3 * NL; i++) begin
            if (done) begin
                lat = cyc - t;
                break;
            end
            step();
        end
        check({nm, "_done_seen"}, 32'(lat >= 0), 32'd1);
    endtask

    localparam logic [HW-1:0] TGT = {64'h0000_00FF_1234_5678, 64'hDEAD_BEEF_0000_0001,
                                     64'h0123_4567_89AB_CDEF, 64'h5555_AAAA_5555_AAAA};

    initial begin
        int lat, dc, rstHold;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0;
        hashes = '0; target = '0; base_nonce = '0;
        #1 chkEn = 1'b1;
        step();
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_found",   32'(found),       32'd0);
        check("rst_nonce",   found_nonce,      32'd0);
        check("rst_overrun", 32'(overrun),     32'd0);
        step();
        n_rst = 1'b1;
        step();

        // Hit on lane 3, base 0x100.
        target = TGT; base_nonce = 32'h100;
        fillAll('1); lane[3] = TGT - 1;
        runBatch("t1", lat);
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_found",   32'(found), 32'd1);
        check("t1_index",   32'(found_index), 32'd3);
        check("t1_nonce",   found_nonce, 32'h103);
        step();
        check("t1_hold_found", 32'(found), 32'd1);
        check("t1_hold_nonce", found_nonce, 32'h103);

        // Equality everywhere is a full miss.
        fillAll(TGT);
        runBatch("t2", lat);
        check("t2_latency", 32'(lat), 32'd11);
        check("t2_found",   32'(found), 32'd0);
        step();

        // Two hits: the lower lane wins.
        fillAll('1); lane[2] = TGT - 5; lane[7] = TGT - 9;
        runBatch("t3", lat);
        check("t3_latency", 32'(lat), 32'd4);
        check("t3_index",   32'(found_index), 32'd2);
        step();

        // Nonce wrap.
        base_nonce = 32'hFFFF_FFFF;
        fillAll('1); lane[1] = '0;
        runBatch("t4", lat);
        check("t4_index", 32'(found_index), 32'd1);
        check("t4_nonce", found_nonce, 32'h0000_0000);
        step();

        // Second start during SCAN is ignored and flags overrun.
        base_nonce = 32'h40;
        fillAll('1); lane[8] = TGT - 1;
        applyLanes();
        start = 1'b1;
        dc = cyc;
        step(); start = 1'b0;
        step(); step();
        fillAll('0); applyLanes(); base_nonce = 32'h999;
        start = 1'b1;
        step(); start = 1'b0;
        check("t5_overrun", 32'(overrun), 32'd1);
        lat = -1;
        for (int i = 0; i < 3 * NL; i++) begin
            if (done) begin lat = cyc - dc; break; end
            step();
        end
        check("t5_latency", 32'(lat), 32'd10);
        check("t5_index",   32'(found_index), 32'd8);
        check("t5_nonce",   found_nonce, 32'h48);
        step();
        abort = 1'b1;
        step(); abort = 1'b0;
        check("t5_abort_overrun", 32'(overrun), 32'd0);
        check("t5_abort_found",   32'(found), 32'd0);

        // Abort mid-scan suppresses done.
        fillAll(TGT); applyLanes();
        dc = doneCount;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        abort = 1'b1; step(); abort = 1'b0;
        check("t6_abort_busy", 32'(busy), 32'd0);
        repeat (15) step();
        check("t6_no_done", 32'(doneCount - dc), 32'd0);

        // Abort and start together: start dropped, no overrun.
        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0;
        check("t7_busy",    32'(busy), 32'd0);
        check("t7_overrun", 32'(overrun), 32'd0);
        step();

        // Reset at t+3 of a scan.
        fillAll('1); lane[5] = TGT - 1; applyLanes();
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        n_rst = 1'b0;
        #1;
        check("t8_rst_busy",  32'(busy), 32'd0);
        check("t8_rst_done",  32'(done), 32'd0);
        check("t8_rst_found", 32'(found), 32'd0);
        check("t8_rst_index", 32'(found_index), 32'd0);
        check("t8_rst_nonce", found_nonce, 32'd0);
        dc = doneCount;
        step(); step();
        n_rst = 1'b1;
        repeat (15) step();
        check("t8_no_done", 32'(doneCount - dc), 32'd0);

        // Randomized traffic checked every cycle by the model.
        rstHold = 0;
        for (int n = 0; n < 4000; n++) begin
            target = ($urandom_range(0, 19) == 0) ? '0 : rand256();
            base_nonce = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 5)
                                                      : 32'($urandom);
            for (int i = 0; i < NL; i++) begin
                case ($urandom_range(0, 9))
                    0:       lane[i] = target - 1;
                    1:       lane[i] = target;
                    2:       lane[i] = rand256();
                    default: lane[i] = target | rand256();
                endcase
            end
            applyLanes();
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            if (rstHold > 0) begin
                rstHold--;
                if (rstHold == 0) n_rst = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                n_rst = 1'b0;
                rstHold = 2;
            end
            step();
        end
        start = 1'b0; abort = 1'b0; n_rst = 1'b1;
        repeat (3 * NL) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hash_result_scanner
